// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave backed by NREGS read/write registers, exported flat with per-register write strobes.
// Write and read channels run independent two-state FSMs.
module axi4_lite_slave_regs #(
    parameter int DW    = 32,
    parameter int AW    = 32,
    parameter int NREGS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [AW-1:0]       S_AXI_AWADDR,
    input  logic                S_AXI_AWVALID,
    output logic                S_AXI_AWREADY,
    input  logic [DW-1:0]       S_AXI_WDATA,
    input  logic [DW/8-1:0]     S_AXI_WSTRB,
    input  logic                S_AXI_WVALID,
    output logic                S_AXI_WREADY,
    output logic [1:0]          S_AXI_BRESP,
    output logic                S_AXI_BVALID,
    input  logic                S_AXI_BREADY,
    input  logic [AW-1:0]       S_AXI_ARADDR,
    input  logic                S_AXI_ARVALID,
    output logic                S_AXI_ARREADY,
    output logic [DW-1:0]       S_AXI_RDATA,
    output logic [1:0]          S_AXI_RRESP,
    output logic                S_AXI_RVALID,
    input  logic                S_AXI_RREADY,
    output logic [NREGS*DW-1:0] reg_out,
    output logic [NREGS-1:0]    wr_strobe
);
    // Handshake rule on every channel: a transfer occurs on a rising edge where
    // VALID and READY are both high; a source holds VALID and payload until then.

    localparam int SB  = DW / 8;
    localparam int OFS = $clog2(SB);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    w_state_e          w_state_q, w_state_d;
    r_state_e          r_state_q, r_state_d;
    logic              en_q;
    logic              aw_held_q, aw_held_d;
    logic              w_held_q, w_held_d;
    logic [AW-1:0]     awaddr_q, awaddr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [SB-1:0]     wstrb_q, wstrb_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [NREGS-1:0]  wr_strobe_q, wr_strobe_d;
    logic              rvalid_q, rvalid_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [DW-1:0]     regs_q [NREGS];

    logic [AW-1:0]     wr_idx, rd_idx;
    logic              wr_in_range, rd_in_range;
    logic [DW-1:0]     rd_val;

    // en_q keeps the readies low until the first edge after reset is released.
    assign S_AXI_AWREADY = en_q && (w_state_q == W_IDLE) && !aw_held_q;
    assign S_AXI_WREADY  = en_q && (w_state_q == W_IDLE) && !w_held_q;
    assign S_AXI_ARREADY = en_q && (r_state_q == R_IDLE);
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign wr_strobe     = wr_strobe_q;

    for (genvar g = 0; g < NREGS; g++) begin : g_out
        assign reg_out[g*DW +: DW] = regs_q[g];
    end

    always_comb begin
        w_state_d   = w_state_q;
        aw_held_d   = aw_held_q;
        w_held_d    = w_held_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        wr_strobe_d = '0;
        wr_idx      = awaddr_q >> OFS;
        wr_in_range = wr_idx < AW'(NREGS);
        case (w_state_q)
            W_IDLE: begin
                if (aw_held_q && w_held_q) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = wr_in_range ? OKAY : SLVERR;
                    w_state_d = W_RESP;
                    for (int i = 0; i < NREGS; i++) begin
                        wr_strobe_d[i] = wr_in_range && (wr_idx == AW'(i));
                    end
                end else begin
                    if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                        aw_held_d = 1'b1;
                        awaddr_d  = S_AXI_AWADDR;
                    end
                    if (S_AXI_WVALID && S_AXI_WREADY) begin
                        w_held_d = 1'b1;
                        wdata_d  = S_AXI_WDATA;
                        wstrb_d  = S_AXI_WSTRB;
                    end
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d   = r_state_q;
        rvalid_d    = rvalid_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;
        rd_idx      = S_AXI_ARADDR >> OFS;
        rd_in_range = rd_idx < AW'(NREGS);
        rd_val      = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (rd_idx == AW'(i)) rd_val = regs_q[i];
        end
        case (r_state_q)
            R_IDLE: begin
                if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_in_range ? rd_val : '0;
                    rresp_d   = rd_in_range ? OKAY : SLVERR;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q        <= 1'b0;
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= OKAY;
            wr_strobe_q <= '0;
            rvalid_q    <= 1'b0;
            rresp_q     <= OKAY;
            rdata_q     <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            en_q        <= 1'b1;
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            aw_held_q   <= aw_held_d;
            w_held_q    <= w_held_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            wr_strobe_q <= wr_strobe_d;
            rvalid_q    <= rvalid_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
            // A register's strobe bit doubles as its commit enable.
            for (int i = 0; i < NREGS; i++) begin
                if (wr_strobe_d[i]) begin
                    for (int k = 0; k < SB; k++) begin
                        if (wstrb_q[k]) regs_q[i][k*8 +: 8] <= wdata_q[k*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed bench for axi4_lite_slave_regs: hand-computed expectations for each AXI4-Lite scenario.
module tb_axi4_lite_slave_regs;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int NREGS = 16;
    localparam int RW    = NREGS * DW;

    logic              clk = 1'b0;
    logic              reset;
    logic [AW-1:0]     awaddr;
    logic              awvalid;
    logic              awready;
    logic [DW-1:0]     wdata;
    logic [DW/8-1:0]   wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [AW-1:0]     araddr;
    logic              arvalid;
    logic              arready;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [RW-1:0]     reg_out;
    logic [NREGS-1:0]  wr_strobe;

    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0] exp_regs [NREGS];

    axi4_lite_slave_regs #(.DW(DW), .AW(AW), .NREGS(NREGS)) dut (
        .clk(clk), .reset(reset),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reg_out(reg_out), .wr_strobe(wr_strobe)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] packed_regs();
        logic [RW-1:0] v;
        for (int i = 0; i < NREGS; i++) v[i*DW +: DW] = exp_regs[i];
        return v;
    endfunction

    task automatic drive_aw(input logic [AW-1:0] a);
        awaddr  = a;
        awvalid = 1'b1;
    endtask

    task automatic drive_w(input logic [DW-1:0] d, input logic [DW/8-1:0] s);
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
        for (int i = 0; i < NREGS; i++) exp_regs[i] = '0;

        // Reset state
        tick(); tick();
        check("rst_awready", RW'(awready), '0);
        check("rst_arready", RW'(arready), '0);
        check("rst_bvalid", RW'(bvalid), '0);
        check("rst_rvalid", RW'(rvalid), '0);
        check("rst_reg_out", reg_out, '0);
        reset = 1'b0;
        check("rel_wready_low", RW'(wready), '0);
        tick();
        check("rel_awready", RW'(awready), 1);
        check("rel_wready", RW'(wready), 1);
        check("rel_arready", RW'(arready), 1);

        // 1: AW and W in the same cycle
        bready = 1'b1;
        drive_aw(32'h08);
        drive_w(32'hDEADBEEF, 4'hF);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("t1_bvalid_early", RW'(bvalid), '0);
        check("t1_awready_held", RW'(awready), '0);
        tick();
        exp_regs[2] = 32'hDEADBEEF;
        check("t1_bvalid", RW'(bvalid), 1);
        check("t1_bresp", RW'(bresp), 0);
        check("t1_reg_out", reg_out, packed_regs());
        check("t1_strobe", RW'(wr_strobe), 16'h0004);
        tick();
        check("t1_bvalid_done", RW'(bvalid), '0);
        check("t1_strobe_done", RW'(wr_strobe), '0);

        // 2: W three cycles ahead of AW, partial strobes
        drive_w(32'h12345678, 4'h3);
        tick();
        wvalid = 1'b0;
        check("t2_wready_drop", RW'(wready), '0);
        check("t2_awready", RW'(awready), 1);
        tick(); tick();
        drive_aw(32'h08);
        tick();
        awvalid = 1'b0;
        check("t2_reg_before", reg_out, packed_regs());
        check("t2_bvalid_early", RW'(bvalid), '0);
        tick();
        exp_regs[2] = 32'hDEAD5678;
        check("t2_reg_after", reg_out, packed_regs());
        check("t2_bvalid", RW'(bvalid), 1);
        tick();

        // 3: read with RREADY held low
        araddr = 32'h0A; arvalid = 1'b1;
        check("t3_arready_idle", RW'(arready), 1);
        tick();
        arvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("t3_rvalid", RW'(rvalid), 1);
            check("t3_rdata", RW'(rdata), 32'hDEAD5678);
            check("t3_rresp", RW'(rresp), 0);
            check("t3_arready", RW'(arready), '0);
            if (c < 4) tick();
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("t3_rvalid_done", RW'(rvalid), '0);
        check("t3_arready_back", RW'(arready), 1);

        // 4: out-of-range write and read in the same cycle
        drive_aw(32'h40);
        drive_w(32'hFFFFFFFF, 4'hF);
        araddr = 32'h40; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("t4_rvalid", RW'(rvalid), 1);
        check("t4_rresp", RW'(rresp), 2);
        check("t4_rdata", RW'(rdata), '0);
        tick();
        check("t4_bvalid", RW'(bvalid), 1);
        check("t4_bresp", RW'(bresp), 2);
        check("t4_strobe", RW'(wr_strobe), '0);
        check("t4_reg_out", reg_out, packed_regs());
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("t4_done", RW'({bvalid, rvalid}), '0);

        // 5: BREADY low with a second write waiting
        bready = 1'b0;
        drive_aw(32'h0C);
        drive_w(32'h11112222, 4'hF);
        tick();
        drive_aw(32'h10);
        drive_w(32'hCAFEF00D, 4'hF);
        tick();
        exp_regs[3] = 32'h11112222;
        check("t5_reg3", reg_out, packed_regs());
        check("t5_strobe3", RW'(wr_strobe), 16'h0008);
        for (int c = 0; c < 4; c++) begin
            check("t5_stall_aw", RW'(awready), '0);
            check("t5_stall_w", RW'(wready), '0);
            check("t5_bvalid_hold", RW'({bvalid, bresp}), 3'b100);
            tick();
        end
        bready = 1'b1;
        tick();
        check("t5_bvalid_clear", RW'(bvalid), '0);
        check("t5_awready_back", RW'(awready), 1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        exp_regs[4] = 32'hCAFEF00D;
        check("t5_reg4", reg_out, packed_regs());
        check("t5_strobe4", RW'(wr_strobe), 16'h0010);
        check("t5_bvalid2", RW'(bvalid), 1);
        tick();

        // Zero strobes: OKAY, strobe pulses, no data change
        drive_aw(32'h00);
        drive_w(32'hFFFFFFFF, 4'h0);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        check("z_strobe", RW'(wr_strobe), 16'h0001);
        check("z_bresp", RW'({bvalid, bresp}), 3'b100);
        check("z_reg_out", reg_out, packed_regs());
        tick();

        // 6: reset while both responses are pending
        bready = 1'b0;
        drive_aw(32'h14);
        drive_w(32'h00000055, 4'hF);
        araddr = 32'h0C; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        tick();
        check("t6_pending", RW'({bvalid, rvalid}), 2'b11);
        reset = 1'b1;
        tick();
        for (int i = 0; i < NREGS; i++) exp_regs[i] = '0;
        check("t6_valids", RW'({bvalid, rvalid}), '0);
        check("t6_reg_out", reg_out, packed_regs());
        check("t6_readies", RW'({awready, wready, arready}), '0);
        check("t6_rdata", RW'(rdata), '0);
        tick();
        reset = 1'b0;
        check("t6_readies_low", RW'({awready, wready, arready}), '0);
        tick();
        check("t6_readies_back", RW'({awready, wready, arready}), 3'b111);
        check("t6_no_resp", RW'({bvalid, rvalid}), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
